// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg
// Purpose  : Shared types and key-code constants for the calculator
//            controller and its digit accumulators.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

  // ALU operation encoding as seen on the ALU op input
  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } alu_op_t;

  // Keypad codes above the digits 0-9; 16-31 are reserved
  localparam logic [4:0] KEY_ADD = 5'd10;
  localparam logic [4:0] KEY_SUB = 5'd11;
  localparam logic [4:0] KEY_MUL = 5'd12;
  localparam logic [4:0] KEY_DIV = 5'd13;
  localparam logic [4:0] KEY_EQ  = 5'd14;
  localparam logic [4:0] KEY_CLR = 5'd15;

  // Controller states
  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_OP   = 3'd1,
    S_B    = 3'd2,
    S_EXEC = 3'd3,
    S_RES  = 3'd4,
    S_ERR  = 3'd5
  } calc_state_t;

  // Operator keys are contiguous from KEY_ADD in the same order as alu_op_t
  function automatic alu_op_t key_to_op(input logic [4:0] key);
    logic [4:0] w_ofs;
    w_ofs = key - KEY_ADD;
    return alu_op_t'(w_ofs[1:0]);
  endfunction

endpackage : calc_pkg
`default_nettype wire

// File: rtl/calc_digit_acc.sv
`default_nettype none
// ============================================================================
// Module   : calc_digit_acc
// Purpose  : Decimal operand accumulator. Holds a W-bit value and the number
//            of digits entered; appends digits with value*10+d up to
//            MAX_DIGITS, beyond which further digits are dropped.
// Revision : 1.0 - initial release
// ============================================================================
module calc_digit_acc #(
  parameter int W          = 20,
  parameter int MAX_DIGITS = 6,
  parameter int CNT_W      = $clog2(MAX_DIGITS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clear,
  input  logic             i_load,
  input  logic [W-1:0]     i_load_val,
  input  logic [CNT_W-1:0] i_load_cnt,
  input  logic             i_accum,
  input  logic [3:0]       i_digit,
  output logic [W-1:0]     o_value
);

  logic [W-1:0]     r_value;
  logic [CNT_W-1:0] r_count;
  logic             w_room;
  logic [W-1:0]     w_next_val;

  assign w_room     = (r_count < CNT_W'(MAX_DIGITS));
  assign w_next_val = (r_value * W'(10)) + W'(i_digit);

  // Value/count register: clear beats load, load beats accumulate
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_value <= '0;
      r_count <= '0;
    end else if (i_load) begin
      r_value <= i_load_val;
      r_count <= i_load_cnt;
    end else if (i_accum && w_room) begin
      r_value <= w_next_val;
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_value = r_value;

endmodule : calc_digit_acc
`default_nettype wire

// File: rtl/calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : calc_ctrl
// Purpose  : Keypad-driven controller for a combinational ALU. Builds decimal
//            operands A and B, issues the operation for one cycle in S_EXEC,
//            folds the result back into A and supports operator chaining.
// Revision : 1.0 - initial release
// ============================================================================
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int W          = 20,
  parameter int MAX_DIGITS = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid,
  input  logic [4:0]   key_code,
  output logic         key_ready,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [1:0]   alu_op,
  input  logic [W-1:0] alu_res,
  output logic [W-1:0] display,
  output logic         result_valid,
  output logic         err
);

  localparam int CNT_W = $clog2(MAX_DIGITS + 1);

  calc_state_t r_state;
  alu_op_t     r_op;
  alu_op_t     r_pend_op;
  logic        r_pend_valid;
  logic        r_result_valid;
  logic        r_err;

  logic             w_accept;
  logic             w_is_digit;
  logic             w_is_op;
  logic             w_is_eq;
  logic             w_is_clr;
  logic [3:0]       w_digit;
  logic             w_a_clear, w_a_load, w_a_accum;
  logic [W-1:0]     w_a_load_val;
  logic [CNT_W-1:0] w_a_load_cnt;
  logic             w_b_clear, w_b_load, w_b_accum;
  logic [W-1:0]     w_acc_a, w_acc_b;

  assign w_accept   = key_valid && (r_state != S_EXEC);
  assign w_is_digit = (key_code <= 5'd9);
  assign w_is_op    = (key_code >= KEY_ADD) && (key_code <= KEY_DIV);
  assign w_is_eq    = (key_code == KEY_EQ);
  assign w_is_clr   = (key_code == KEY_CLR);
  assign w_digit    = key_code[3:0];

  // Accumulator control decode from the current state and the accepted key
  always_comb begin
    w_a_clear    = w_accept && w_is_clr;
    w_a_accum    = w_accept && w_is_digit && (r_state == S_A);
    w_a_load     = 1'b0;
    w_a_load_val = W'(w_digit);
    w_a_load_cnt = CNT_W'(1);
    if (r_state == S_EXEC) begin
      // Result becomes the new A; any digit after it starts a fresh operand
      w_a_load     = 1'b1;
      w_a_load_val = alu_res;
      w_a_load_cnt = '0;
    end else if (w_accept && w_is_digit && (r_state == S_RES)) begin
      w_a_load = 1'b1;
    end
    w_b_clear = (w_accept && w_is_clr) ||
                (w_accept && w_is_op && ((r_state == S_A) || (r_state == S_RES))) ||
                ((r_state == S_EXEC) && r_pend_valid);
    w_b_load  = w_accept && w_is_digit && (r_state == S_OP);
    w_b_accum = w_accept && w_is_digit && (r_state == S_B);
  end

  calc_digit_acc #(.W(W), .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_acc_a (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_a_clear),
    .i_load     (w_a_load),
    .i_load_val (w_a_load_val),
    .i_load_cnt (w_a_load_cnt),
    .i_accum    (w_a_accum),
    .i_digit    (w_digit),
    .o_value    (w_acc_a)
  );

  calc_digit_acc #(.W(W), .MAX_DIGITS(MAX_DIGITS), .CNT_W(CNT_W)) u_acc_b (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_b_clear),
    .i_load     (w_b_load),
    .i_load_val (W'(w_digit)),
    .i_load_cnt (CNT_W'(1)),
    .i_accum    (w_b_accum),
    .i_digit    (w_digit),
    .o_value    (w_acc_b)
  );

  // Main FSM: state, operator registers and registered status outputs
  always_ff @(posedge clk) begin
    r_result_valid <= 1'b0;
    if (rst || (w_accept && w_is_clr)) begin
      r_state      <= S_A;
      r_op         <= ADD;
      r_pend_op    <= ADD;
      r_pend_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_A, S_RES: begin
          if (w_accept && w_is_op) begin
            r_op    <= key_to_op(key_code);
            r_state <= S_OP;
          end else if (w_accept && w_is_digit && (r_state == S_RES)) begin
            r_state <= S_A;
          end
        end
        S_OP: begin
          if (w_accept && w_is_op) begin
            r_op <= key_to_op(key_code);
          end else if (w_accept && w_is_digit) begin
            r_state <= S_B;
          end
        end
        S_B: begin
          if (w_accept && (w_is_op || w_is_eq)) begin
            if ((r_op == DIV) && (w_acc_b == '0)) begin
              r_state <= S_ERR;
              r_err   <= 1'b1;
            end else begin
              r_state      <= S_EXEC;
              r_pend_valid <= w_is_op;
              r_pend_op    <= key_to_op(key_code);
            end
          end
        end
        S_EXEC: begin
          r_result_valid <= 1'b1;
          if (r_pend_valid) begin
            r_op         <= r_pend_op;
            r_pend_valid <= 1'b0;
            r_state      <= S_OP;
          end else begin
            r_state <= S_RES;
          end
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_A;
        end
      endcase
    end
  end

  // Display source select; in S_EXEC B is still untouched, so it holds
  always_comb begin
    display = w_acc_a;
    case (r_state)
      S_B, S_EXEC: display = w_acc_b;
      S_ERR:       display = '0;
      default:     display = w_acc_a;
    endcase
  end

  assign key_ready    = (r_state != S_EXEC);
  assign alu_a        = w_acc_a;
  assign alu_b        = w_acc_b;
  assign alu_op       = r_op;
  assign result_valid = r_result_valid;
  assign err          = r_err;

endmodule : calc_ctrl
`default_nettype wire

// File: tb/tb_calc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_calc_ctrl
// Purpose  : Self-checking bench for calc_ctrl: directed keypad sequences and
//            random key streams against a behavioural calculator model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_calc_ctrl;

  localparam int     W    = 20;
  localparam longint MASK = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         key_valid = 1'b0;
  logic [4:0]   key_code = '0;
  logic         key_ready;
  logic [W-1:0] alu_a, alu_b, alu_res, display;
  logic [1:0]   alu_op;
  logic         result_valid, err;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model: mode 0=entering A, 1=after operator, 2=entering B,
  // 4=showing result, 5=error
  longint m_a, m_b;
  int     m_cnt, m_op, m_mode;
  bit     m_err;
  longint p_a, p_b;
  int     p_op;

  always #5 clk = ~clk;

  calc_ctrl #(.W(W), .MAX_DIGITS(6)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_op       (alu_op),
    .alu_res      (alu_res),
    .display      (display),
    .result_valid (result_valid),
    .err          (err)
  );

  // Combinational ALU the controller drives
  always_comb begin
    alu_res = '0;
    case (alu_op)
      2'b00: alu_res = alu_a + alu_b;
      2'b01: alu_res = alu_a - alu_b;
      2'b10: alu_res = alu_a * alu_b;
      default: alu_res = (alu_b == '0) ? '0 : alu_a / alu_b;
    endcase
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic longint model_calc(input longint a, input longint b, input int op);
    case (op)
      0: return (a + b) & MASK;
      1: return (a - b) & MASK;
      2: return (a * b) & MASK;
      default: return (b == 0) ? 0 : a / b;
    endcase
  endfunction

  task automatic model_reset();
    m_a = 0; m_b = 0; m_cnt = 0; m_op = 0; m_mode = 0; m_err = 0;
  endtask

  function automatic longint model_display();
    if (m_mode == 5) return 0;
    if (m_mode == 2) return m_b;
    return m_a;
  endfunction

  // Apply one consumed key to the model; ex=1 when an ALU operation runs
  task automatic model_key(input int k, output bit ex);
    ex = 0;
    p_a = m_a; p_b = m_b; p_op = m_op;
    if (k == 15) begin
      model_reset();
    end else if (m_mode == 5 || k > 15) begin
      // ignored
    end else if (k <= 9) begin
      case (m_mode)
        0: if (m_cnt < 6) begin m_a = m_a * 10 + k; m_cnt++; end
        1: begin m_b = k; m_cnt = 1; m_mode = 2; end
        2: if (m_cnt < 6) begin m_b = m_b * 10 + k; m_cnt++; end
        default: begin m_a = k; m_cnt = 1; m_mode = 0; end
      endcase
    end else if (k <= 13) begin
      if (m_mode == 2) begin
        if (m_op == 3 && m_b == 0) begin
          m_mode = 5; m_err = 1;
        end else begin
          ex = 1; m_a = model_calc(m_a, m_b, m_op);
          m_op = k - 10; m_b = 0; m_cnt = 0; m_mode = 1;
        end
      end else begin
        if (m_mode != 1) begin m_b = 0; m_cnt = 0; end
        m_op = k - 10; m_mode = 1;
      end
    end else begin
      if (m_mode == 2) begin
        if (m_op == 3 && m_b == 0) begin
          m_mode = 5; m_err = 1;
        end else begin
          ex = 1; m_a = model_calc(m_a, m_b, m_op); m_mode = 4;
        end
      end
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, ".display"}, display, model_display());
    check({tag, ".err"}, err, m_err);
    check({tag, ".ready"}, key_ready, 1);
    check({tag, ".alu_a"}, alu_a, m_a);
    check({tag, ".alu_b"}, alu_b, m_b);
    check({tag, ".alu_op"}, alu_op, m_op);
  endtask

  // Present one key for one cycle and check the outcome (including EXEC)
  task automatic press(input int k, input string tag);
    bit ex;
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 5'(k);
    @(posedge clk); #1;
    key_valid = 1'b0;
    model_key(k, ex);
    if (ex) begin
      check({tag, ".exec_ready"}, key_ready, 0);
      check({tag, ".exec_a"}, alu_a, p_a);
      check({tag, ".exec_b"}, alu_b, p_b);
      check({tag, ".exec_op"}, alu_op, p_op);
      check({tag, ".exec_disp"}, display, p_b);
      check({tag, ".exec_rv"}, result_valid, 0);
      @(posedge clk); #1;
      check({tag, ".rv"}, result_valid, 1);
    end else begin
      check({tag, ".rv"}, result_valid, 0);
    end
    check_state(tag);
  endtask

  task automatic press_seq(input int keys[$], input string tag);
    foreach (keys[i]) press(keys[i], tag);
  endtask

  initial begin
    bit ex;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("reset.display", display, 0);
    check("reset.rv", result_valid, 0);
    check("reset.err", err, 0);
    check("reset.ready", key_ready, 1);
    check("reset.alu_op", alu_op, 0);

    // 123 + 321
    press_seq('{1, 2, 3, 10, 3, 2, 1, 14}, "add");
    check("add.result", display, 444);
    press(15, "clr");

    // 28 - 6, then chain *3 from the result
    press_seq('{2, 8, 11, 6, 14}, "sub");
    check("sub.result", display, 22);
    press_seq('{12, 3, 14}, "chain");
    check("chain.result", display, 66);
    press(15, "clr");

    // 36*17 then +8 via operator chaining
    press_seq('{3, 6, 12, 1, 7, 10}, "mulchain");
    check("mulchain.mid", display, 612);
    check("mulchain.op", alu_op, 0);
    press_seq('{8, 14}, "mulchain2");
    check("mulchain.result", display, 620);
    press(15, "clr");

    // Divide by zero, ignored digit, clear
    press_seq('{1, 2, 13, 0, 14}, "div0");
    check("div0.err", err, 1);
    press(5, "div0.ignored");
    press(15, "div0.clr");
    check("div0.cleared", err, 0);

    // Digit limit
    press_seq('{1, 2, 3, 4, 5, 6, 7, 8}, "limit");
    check("limit.display", display, 123456);
    press(15, "clr");

    // SUB underflow wraps; reserved codes are ignored
    press_seq('{3, 20, 11, 31, 5, 14}, "under");
    check("under.result", display, (3 - 5) & MASK);
    press(15, "clr");

    // key_valid held across S_EXEC: key 5 waits one cycle, then is consumed
    press_seq('{2, 10, 4}, "hold");
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'd14;
    @(posedge clk); #1;
    model_key(14, ex);
    key_code = 5'd5;
    check("hold.exec_ready", key_ready, 0);
    @(posedge clk); #1;
    check("hold.ready_back", key_ready, 1);
    check("hold.rv", result_valid, 1);
    check("hold.result", display, 6);
    @(posedge clk); #1;
    key_valid = 1'b0;
    model_key(5, ex);
    check("hold.rv_after", result_valid, 0);
    check_state("hold.consumed");

    // Reset during S_EXEC aborts the operation
    press_seq('{15, 7, 12, 8}, "rstexec");
    @(negedge clk);
    key_valid = 1'b1; key_code = 5'd14;
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("rstexec.exec_ready", key_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    check("rstexec.rv", result_valid, 0);
    check_state("rstexec");
    @(posedge clk); #1;
    check("rstexec.rv_late", result_valid, 0);

    // Random key stream against the model
    for (int n = 0; n < 500; n++) begin
      int r, k;
      r = $urandom_range(0, 99);
      if (r < 55)      k = $urandom_range(0, 9);
      else if (r < 75) k = 10 + $urandom_range(0, 3);
      else if (r < 87) k = 14;
      else if (r < 90) k = 15;
      else if (r < 94) k = $urandom_range(16, 31);
      else             k = 0;
      press(k, "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  // Absolute time bound so the run always ends
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL timeout: got=running expected=finished");
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1);
  end

endmodule : tb_calc_ctrl
`default_nettype wire

// File: doc/calc_ctrl.md
Name: calc_ctrl

Overview:
- Initiator-side controller for the calculator's combinational ALU (20-bit A/B, 2-bit op, 20-bit res).
- Accepts keypad key codes and builds decimal operands A and B plus an operation.
- Drives the ALU inputs, captures res, and presents a display value.
- Sits between the keypad decoder and the ALU/display path.

Parameters:
- W, 20: operand/result width; matches ALU A, B, res.
- MAX_DIGITS, 6: max decimal digits per operand; 999999 fits in W=20.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- key_valid  in  1  key code present this cycle.
- key_code  in  5  0-9 digit, 10 ADD, 11 SUB, 12 MUL, 13 DIV, 14 EQ, 15 CLR; 16-31 reserved.
- key_ready  out  1  controller can accept a key; key is consumed when key_valid && key_ready.
- alu_a  out  W  ALU operand A, registered.
- alu_b  out  W  ALU operand B, registered.
- alu_op  out  2  ALU op: 00 ADD, 01 SUB, 10 MUL, 11 DIV; registered.
- alu_res  in  W  ALU result, combinational from alu_a/alu_b/alu_op.
- display  out  W  value to show.
- result_valid  out  1  one-cycle pulse when a new result is loaded.
- err  out  1  divide-by-zero latched.

Behaviour:
- Reset: synchronous, active-high; this is fixed.
  - State S_A; acc_a=0, acc_b=0, op_reg=00, pend_op=00, digit count=0.
  - Outputs: display=0, result_valid=0, err=0, key_ready=1.
  - Reset mid-EXEC aborts the operation; no result is captured.
- Output sources: alu_a=acc_a, alu_b=acc_b, alu_op=op_reg, all from registers.
- key_ready=0 only in S_EXEC. Keys presented while key_ready=0 are not consumed and not queued.
- Reserved codes are consumed and ignored.
- Digit entry: acc <= acc*10 + d, count+1. Digits are ignored (but consumed) when count==MAX_DIGITS.
- States and transitions (all on an accepted key):
  - S_A:
    - digit -> accumulate into acc_a.
    - op key -> op_reg=key, clear acc_b and count, go S_OP.
    - EQ -> ignored.
  - S_OP:
    - digit -> acc_b=d, count=1, go S_B.
    - op key -> replace op_reg.
    - EQ -> ignored.
  - S_B:
    - digit -> accumulate into acc_b.
    - EQ -> go S_EXEC, pend_op=none.
    - op key -> go S_EXEC, pend_op=key (chaining).
    - If op_reg==DIV and acc_b==0 on EQ or op key -> go S_ERR instead.
  - S_EXEC (one cycle; no key accepted):
    - acc_a <= alu_res.
    - result_valid=1 in the following cycle.
    - With no pend_op -> go S_RES.
    - With pend_op -> op_reg=pend_op, acc_b=0, count=0, go S_OP.
  - S_RES:
    - digit -> acc_a=d, count=1, go S_A.
    - op key -> chain as in S_A.
    - EQ -> ignored.
  - S_ERR: err=1, display=0. All keys except CLR are ignored.
  - CLR in any state where key_ready=1 -> same as reset. CLR takes priority over everything else.
- Display:
  - S_A, S_OP, S_RES show acc_a.
  - S_B shows acc_b.
  - S_ERR shows 0.
  - S_EXEC holds the previous display value.
- Latency: EQ accepted in cycle N -> S_EXEC in N+1 -> display=result and result_valid=1 in N+2.
- Arithmetic: the controller does no arithmetic on results.
  - SUB underflow passes through as the W-bit two's-complement value from the ALU.
  - MUL overflow is the ALU's truncated value.

Decomposition:
- Shared package calc_pkg contains:
  - alu_op_t enum (ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11).
  - Key-code localparams (KEY_ADD=10 ... KEY_CLR=15).
  - calc_state_t enum (S_A, S_OP, S_B, S_EXEC, S_RES, S_ERR).
- One sub-module, calc_digit_acc:
  - W-bit register plus digit counter.
  - Ports: load, accumulate, clear.
  - Implements the *10+d step and the MAX_DIGITS limit.
  - Instanced twice, for A and B.

Test Plan:
- Keys 1,2,3,ADD,3,2,1,EQ -> alu_a=123, alu_b=321, alu_op=00 in EXEC; display=444 and result_valid pulse 2 cycles after EQ.
- 2,8,SUB,6,EQ -> display=22. Then MUL,3,EQ (chain from S_RES) -> display=66.
- 3,6,MUL,1,7,ADD,8,EQ -> after ADD: display=612, op=ADD, state S_OP; final display=620.
- 1,2,DIV,0,EQ -> S_ERR, err=1, display=0. Digit 5 is ignored. CLR -> err=0, display=0, state S_A.
- Digits 1,2,3,4,5,6,7,8 -> display=123456; the 7th and 8th digits are consumed and ignored.
- key_valid held high with key 5 across S_EXEC -> key_ready=0 for exactly 1 cycle. rst asserted during S_EXEC -> next cycle all outputs at reset values, no result_valid.
